comparator_seq_param: RTL and testbench



---
 rtl/comparator_seq_param_if.sv | 33 +++
 rtl/comparator_seq_param.sv | 166 ++++++++++++++++
 tb/tb_comparator_seq_param.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/comparator_seq_param_if.sv
// ----------------------------------------------------------------------------
// comparator_seq_param_if
//   Request/response bundle for comparator_seq_param.
//
//   Requester -> comparator : start, sgn, A, B
//   Comparator -> requester : busy, done, A_gt, A_lt, A_eq
//
//   master modport : the side that issues compares (drives start/sgn/A/B)
//   slave  modport : the comparator itself
// ----------------------------------------------------------------------------
interface comparator_seq_param_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             A_gt;
    logic             A_lt;
    logic             A_eq;

    modport master (
        output start, sgn, A, B,
        input  busy, done, A_gt, A_lt, A_eq
    );

    modport slave (
        input  start, sgn, A, B,
        output busy, done, A_gt, A_lt, A_eq
    );
endinterface

// File: rtl/comparator_seq_param.sv
// ----------------------------------------------------------------------------
// comparator_seq_param
//   Multi-cycle magnitude comparator. Two WIDTH-bit operands are compared
//   CHUNK bits per clock, most significant chunk first, in either unsigned or
//   two's-complement mode. Results are registered and held until the next
//   accepted start.
//
//   Ports
//     clk  : system clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : comparator_seq_param_if.slave
//              start        request a compare (accepted when busy=0)
//              sgn, A, B    mode and operands, sampled with start
//              busy         compare in progress
//              done         one-cycle pulse, results valid from this cycle
//              A_gt/A_lt/A_eq  registered, held results
//
//   Build option
//     CMP_EARLY_EXIT_EN : when defined, the first differing chunk ends the
//                         compare (latency 1..NCHUNK). When undefined, every
//                         compare walks all NCHUNK chunks; results are the
//                         same, only timing differs.
// ----------------------------------------------------------------------------
module comparator_seq_param #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    comparator_seq_param_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(NCHUNK - 1);
    // Flipping the MSB of the top chunk maps two's-complement order onto
    // unsigned order, so one unsigned chunk compare serves both modes.
    localparam logic [CHUNK-1:0] SIGN_FLIP = CHUNK'(1) << (CHUNK - 1);

    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_param
            $error("comparator_seq_param: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q;
    logic [IDX_W-1:0] idx_q;

    // Outcome of the first differing chunk, remembered while the remaining
    // chunks are walked (only ever set when early exit is disabled).
    logic             decided_q;
    logic             gt_pend_q, lt_pend_q;

    logic             gt_q, lt_q, eq_q;

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic             chunk_gt, chunk_lt;
    logic             gt_now, lt_now;
    logic             last_chunk, finish, accept;

    // ------------------------------------------------------------------
    // Chunk compare datapath
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        a_chunk = a_q[int'(idx_q) * CHUNK +: CHUNK];
        b_chunk = b_q[int'(idx_q) * CHUNK +: CHUNK];
        if (sgn_q && (idx_q == IDX_TOP)) begin
            a_chunk = a_chunk ^ SIGN_FLIP;
            b_chunk = b_chunk ^ SIGN_FLIP;
        end

        chunk_gt   = (a_chunk > b_chunk);
        chunk_lt   = (a_chunk < b_chunk);
        // A decision already taken on a higher chunk overrides this one.
        gt_now     = decided_q ? gt_pend_q : chunk_gt;
        lt_now     = decided_q ? lt_pend_q : chunk_lt;
        last_chunk = (idx_q == '0);
`ifdef CMP_EARLY_EXIT_EN
        finish     = last_chunk || chunk_gt || chunk_lt;
`else
        finish     = last_chunk;
`endif
        // A start is honoured in IDLE and in the DONE cycle, never in CMP.
        accept     = bus.start && (state_q != ST_CMP);
    end

    // ------------------------------------------------------------------
    // FSM: state register + next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_CMP;
            ST_CMP:  if (finish)    state_d = ST_DONE;
            ST_DONE: state_d = bus.start ? ST_CMP : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, index and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            gt_pend_q <= 1'b0;
            lt_pend_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
        end else if (accept) begin
            a_q       <= bus.A;
            b_q       <= bus.B;
            sgn_q     <= bus.sgn;
            idx_q     <= IDX_TOP;
            decided_q <= 1'b0;
            gt_pend_q <= 1'b0;
            lt_pend_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
        end else if (state_q == ST_CMP) begin
            if (finish) begin
                gt_q <= gt_now;
                lt_q <= lt_now;
                eq_q <= !gt_now && !lt_now;
            end else begin
                idx_q <= idx_q - 1'b1;
                if (!decided_q && (chunk_gt || chunk_lt)) begin
                    decided_q <= 1'b1;
                    gt_pend_q <= chunk_gt;
                    lt_pend_q <= chunk_lt;
                end
            end
        end
    end

    assign bus.busy = (state_q == ST_CMP);
    assign bus.done = (state_q == ST_DONE);
    assign bus.A_gt = gt_q;
    assign bus.A_lt = lt_q;
    assign bus.A_eq = eq_q;

endmodule

// File: tb/tb_comparator_seq_param.sv
// ----------------------------------------------------------------------------
// tb_comparator_seq_param
//   Directed bench for comparator_seq_param (WIDTH=16, CHUNK=4). The driver
//   pushes the hand-computed result and latency of every accepted compare into
//   a scoreboard queue; an independent monitor pops and checks on each done.
// ----------------------------------------------------------------------------
module tb_comparator_seq_param;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;
`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_LT = 3'b010;
    localparam logic [2:0] R_EQ = 3'b001;

    typedef struct {
        logic [2:0] res;   // {gt, lt, eq}
        int         lat;   // edges from acceptance to done
        int         acc;   // cycle count at the accepting edge
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    comparator_seq_param_if #(.WIDTH(WIDTH)) bus ();

    comparator_seq_param #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [2:0] results();
        return {bus.A_gt, bus.A_lt, bus.A_eq};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", bus.done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", results(), e.res);
                check("latency", cyc - e.acc, e.lat);
            end
        end
    end

    // Called at a negedge with the DUT able to accept. Returns at the negedge
    // after the accepting edge with start deasserted.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [2:0] res, input int lat_early, input bit push);
        exp_t e;
        bus.A     = a;
        bus.B     = b;
        bus.sgn   = s;
        bus.start = 1'b1;
        if (push) begin
            e.res = res;
            e.lat = EARLY ? lat_early : NCHUNK;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check("accept_busy", bus.busy, 1'b1);
        check("accept_done_low", bus.done, 1'b0);
        check("accept_cleared", results(), 3'b000);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!bus.done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("done_timeout", bus.done, 1'b1);
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [2:0] res, input int lat_early);
        issue(a, b, s, res, lat_early, 1'b1);
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        int nbusy;
        bus.start = 1'b0;
        bus.sgn   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_results", results(), 3'b000);
        rst = 1'b0;
        @(negedge clk);

        // Equal operands: busy for all four chunks, results zero meanwhile
        issue(16'h1234, 16'h1234, 1'b0, R_EQ, 4, 1'b1);
        nbusy = 1;
        while (bus.busy && nbusy < 50) begin
            check("cleared_while_busy", results(), 3'b000);
            @(negedge clk);
            if (bus.busy) nbusy++;
        end
        check("busy_cycles", nbusy, 4);
        check("eq_at_done", results(), R_EQ);
        @(negedge clk);

        // Directed vectors
        run(16'h8000, 16'h7FFF, 1'b0, R_GT, 1);
        run(16'h8000, 16'h7FFF, 1'b1, R_LT, 1);
        run(16'h1235, 16'h1234, 1'b0, R_GT, 4);
        run(16'hFFFF, 16'h0001, 1'b1, R_LT, 1);

        // start during busy is ignored
        issue(16'h0001, 16'h0002, 1'b0, R_LT, 4, 1'b1);
        bus.A     = 16'hFFFF;
        bus.B     = 16'h0000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        check("hold_after_done", results(), R_LT);
        check("idle_not_busy", bus.busy, 1'b0);

        // Reset during the second CMP cycle aborts the compare
        issue(16'h5555, 16'h5555, 1'b0, R_EQ, 4, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_results", results(), 3'b000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        run(16'h00A0, 16'h00B0, 1'b0, R_LT, 3);

        // Back-to-back: new start in the DONE cycle
        issue(16'h7000, 16'h1000, 1'b1, R_GT, 1, 1'b1);
        wait_done();
        issue(16'hFFFE, 16'hFFFF, 1'b1, R_LT, 4, 1'b1);
        wait_done();
        @(negedge clk);
        run(16'h0003, 16'h0003, 1'b1, R_EQ, 4);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
